gpio_port: RTL and testbench
============================

// Module: gpio_port
// PURPOSE
// - Parametrised N-pin bidirectional GPIO port with software-programmable per-pin direction.
// - Adds synchronised input sampling, per-pin rising/falling edge detection and a sticky
//   interrupt status register with a single level irq output.
// - Sits on the processor data bus as a small register file (address/write/read) and drives
//   physical pins through tri-state buffers.
// PARAMETERS
// - N            9    number of pins / register width
// - DEBOUNCE_W   8    debounce counter width (used only with GPIO_DEBOUNCE_EN)
// PORTS
// - clock          in     1   rising-edge clock
// - reset          in     1   asynchronous, active-high reset
// - address        in     3   register select
// - write_enable   in     1   write strobe, sampled at posedge clock
// - write_data     in     N   data from processor bus
// - read_data      out    N   data to processor bus (combinational on address)
// - irq            out    1   OR of (status & irq_mask)
// - pin            inout  N   physical pins
// BEHAVIOUR
// - Register map (address: name, access):
//   - 0: DIR, rw (1 = output)
//   - 1: OUT, rw
//   - 2: IN, ro
//   - 3: RISE_EN, rw
//   - 4: FALL_EN, rw
//   - 5: STATUS, write-1-to-clear
//   - 6: IRQ_MASK, rw
//   - 7: reads 0, writes ignored
// - Reset (async, immediate): DIR, OUT, RISE_EN, FALL_EN, STATUS, IRQ_MASK, sync FFs, prev = 0.
//   - All pins high-Z, irq = 0; read_data follows address with reset register values.
// - Pin drive: pin[i] = DIR[i] ? OUT[i] : 1'bz. Direction/data change visible 1 cycle after the write edge.
// - Input path: pin -> 2-FF synchroniser -> sampled[i]. IN = sampled, 2 cycles after a pin change.
//   - Output pins read back their pad value.
// - Edge detect: prev <= sampled every cycle.
//   - rise[i] = sampled & ~prev & RISE_EN; fall[i] = ~sampled & prev & FALL_EN.
// - STATUS[i] <= (STATUS[i] & ~w1c[i]) | rise[i] | fall[i].
//   - w1c = write_data when write_enable && address == 5.
//   - Simultaneous set and clear: set wins, bit stays 1.
// - Enabling RISE_EN/FALL_EN does not retroactively flag a level already present.
//   - Only transitions after the enable edge are captured.
// - Writes to IN or reserved addresses: no effect. Writes to other registers take effect at posedge clock.
// - irq = |(STATUS & IRQ_MASK), combinational from registers. STATUS latches regardless of mask.
// - Reset asserted mid-operation: all state cleared within the same cycle; pending edges lost.
// CONFIGURATION
// - GPIO_DEBOUNCE_EN defined:
//   - Per-pin DEBOUNCE_W-bit counter between synchroniser and edge detect.
//   - stable[i] updates only after sync[i] != stable[i] for 2^DEBOUNCE_W-1 consecutive cycles.
//     Any earlier match resets the counter.
//   - IN and edge detect use stable; added latency 2^DEBOUNCE_W-1 cycles.
// - GPIO_DEBOUNCE_EN undefined: no counters; stable = sync output directly.
// TESTING
// - Reset: assert reset mid-run -> pin = all Z, every register reads 0, irq = 0 without a clock edge.
// - Output: write DIR=0x1FF, OUT=0x0A5 -> pin = 9'h0A5 next cycle; IN reads 0x0A5 two cycles later.
// - Input: DIR=0, RISE_EN=0x001, IRQ_MASK=0x001, drive pin[0] 0->1 -> STATUS=0x001 and irq=1 by cycle 3.
// - Clear race: write STATUS=0x001 in the same cycle as a new pin[0] rise -> STATUS stays 0x001.
//   - A plain W1C later -> 0x000, irq=0.
// - Masking: FALL_EN=0x100, IRQ_MASK=0, drive pin[8] 1->0 -> STATUS=0x100, irq=0.
//   - Then write IRQ_MASK=0x100 -> irq=1.
// - Debounce (GPIO_DEBOUNCE_EN, DEBOUNCE_W=3): 5-cycle glitch on pin[2] -> no IN change, STATUS=0.
//   - Held high 10 cycles -> IN[2]=1.

Source files
------------

// File: rtl/gpio_port.sv
// -----------------------------------------------------------------------------
// gpio_port
//
// Purpose:
//   N-pin bidirectional GPIO port attached to a small processor register file.
//   Each pin direction is programmed in software. Every pin is sampled through
//   a 2-FF synchroniser, and per-pin rising/falling edges set bits in a sticky
//   write-1-to-clear STATUS register. STATUS is masked onto one level irq.
//
// Optional feature macro:
//   GPIO_DEBOUNCE_EN - when defined, a per-pin DEBOUNCE_W-bit counter sits
//                      between the synchroniser and the IN/edge-detect logic.
//                      A new level is accepted only after it has differed from
//                      the accepted level for 2^DEBOUNCE_W-1 consecutive
//                      cycles. When undefined, the synchroniser output is used
//                      directly.
//
// Ports:
//   clock        in     1  rising-edge clock
//   reset        in     1  asynchronous, active-high reset
//   address      in     3  register select (0 DIR, 1 OUT, 2 IN, 3 RISE_EN,
//                          4 FALL_EN, 5 STATUS (W1C), 6 IRQ_MASK, 7 reserved)
//   write_enable in     1  write strobe, sampled at posedge clock
//   write_data   in     N  write data from the processor bus
//   read_data    out    N  read data, combinational on address
//   irq          out    1  |(STATUS & IRQ_MASK)
//   pin          inout  N  physical pins (driven when DIR=1, else high-Z)
// -----------------------------------------------------------------------------
module gpio_port #(
  parameter int N          = 9,
  parameter int DEBOUNCE_W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [2:0]   address,
  input  logic         write_enable,
  input  logic [N-1:0] write_data,
  output logic [N-1:0] read_data,
  output logic         irq,
  inout  wire  [N-1:0] pin
);

  localparam logic [2:0] ADDR_DIR      = 3'd0;
  localparam logic [2:0] ADDR_OUT      = 3'd1;
  localparam logic [2:0] ADDR_IN       = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;

  // Catch illegal parameter combinations at elaboration.
  if (N < 32'sd1 || DEBOUNCE_W < 32'sd2) begin : g_bad_params
    $error("gpio_port: N must be >= 1 and DEBOUNCE_W must be >= 2");
  end

  // Software-visible registers.
  logic [N-1:0] dir_r;
  logic [N-1:0] out_r;
  logic [N-1:0] rise_en_r;
  logic [N-1:0] fall_en_r;
  logic [N-1:0] status_r;
  logic [N-1:0] irq_mask_r;

  // Input path state.
  logic [N-1:0] sync1_r;
  logic [N-1:0] sync2_r;
  logic [N-1:0] stable_s;
  logic [N-1:0] prev_r;

  // Decoded write strobes.
  logic         wr_dir_s;
  logic         wr_out_s;
  logic         wr_rise_en_s;
  logic         wr_fall_en_s;
  logic         wr_irq_mask_s;
  logic [N-1:0] w1c_s;

  // Edge events.
  logic [N-1:0] rise_s;
  logic [N-1:0] fall_s;

  // ---------------------------------------------------------------------------
  // Pin drivers: each pin is driven with OUT only while its DIR bit is set.
  // ---------------------------------------------------------------------------
  for (genvar g = 32'sd0; g < N; g++) begin : g_pad
    assign pin[g] = dir_r[g] ? out_r[g] : 1'bz;
  end

  // Write address decode; IN and the reserved slot decode to nothing.
  always_comb begin
    wr_dir_s      = 1'b0;
    wr_out_s      = 1'b0;
    wr_rise_en_s  = 1'b0;
    wr_fall_en_s  = 1'b0;
    wr_irq_mask_s = 1'b0;
    w1c_s         = {N{1'b0}};
    if (write_enable) begin
      case (address)
        ADDR_DIR:      wr_dir_s      = 1'b1;
        ADDR_OUT:      wr_out_s      = 1'b1;
        ADDR_RISE_EN:  wr_rise_en_s  = 1'b1;
        ADDR_FALL_EN:  wr_fall_en_s  = 1'b1;
        ADDR_STATUS:   w1c_s         = write_data;
        ADDR_IRQ_MASK: wr_irq_mask_s = 1'b1;
        default: begin
          wr_dir_s = 1'b0;
        end
      endcase
    end else begin
      w1c_s = {N{1'b0}};
    end
  end

  // Control register file (DIR, OUT, RISE_EN, FALL_EN, IRQ_MASK).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dir_r      <= {N{1'b0}};
      out_r      <= {N{1'b0}};
      rise_en_r  <= {N{1'b0}};
      fall_en_r  <= {N{1'b0}};
      irq_mask_r <= {N{1'b0}};
    end else begin
      if (wr_dir_s)      dir_r      <= write_data;
      if (wr_out_s)      out_r      <= write_data;
      if (wr_rise_en_s)  rise_en_r  <= write_data;
      if (wr_fall_en_s)  fall_en_r  <= write_data;
      if (wr_irq_mask_s) irq_mask_r <= write_data;
    end
  end

  // Two-flop synchroniser on the pad values (output pins read back their pad).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= {N{1'b0}};
      sync2_r <= {N{1'b0}};
    end else begin
      sync1_r <= pin;
      sync2_r <= sync1_r;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  // Terminal count: the mismatch run has lasted 2^DEBOUNCE_W-1 cycles on the
  // cycle the counter holds 2^DEBOUNCE_W-2 and the mismatch persists.
  localparam logic [DEBOUNCE_W-1:0] DB_LAST = {{(DEBOUNCE_W-1){1'b1}}, 1'b0};
  localparam logic [DEBOUNCE_W-1:0] DB_ONE  = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

  for (genvar g = 32'sd0; g < N; g++) begin : g_debounce
    logic                  stable_bit_r;
    logic [DEBOUNCE_W-1:0] cnt_r;

    // Per-pin debounce: any cycle where sync matches stable restarts the count.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        stable_bit_r <= 1'b0;
        cnt_r        <= {DEBOUNCE_W{1'b0}};
      end else if (sync2_r[g] != stable_bit_r) begin
        if (cnt_r == DB_LAST) begin
          stable_bit_r <= sync2_r[g];
          cnt_r        <= {DEBOUNCE_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + DB_ONE;
        end
      end else begin
        cnt_r <= {DEBOUNCE_W{1'b0}};
      end
    end

    assign stable_s[g] = stable_bit_r;
  end
`else
  assign stable_s = sync2_r;
`endif

  // Edge events compare the current stable level with last cycle's level, so
  // enabling detection never flags a level that was already present.
  assign rise_s = stable_s & ~prev_r & rise_en_r;
  assign fall_s = ~stable_s & prev_r & fall_en_r;

  // Previous-level register for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_r <= {N{1'b0}};
    end else begin
      prev_r <= stable_s;
    end
  end

  // Sticky status: a new edge in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_r <= {N{1'b0}};
    end else begin
      status_r <= (status_r & ~w1c_s) | rise_s | fall_s;
    end
  end

  // Read mux, combinational on address.
  always_comb begin
    read_data = {N{1'b0}};
    case (address)
      ADDR_DIR:      read_data = dir_r;
      ADDR_OUT:      read_data = out_r;
      ADDR_IN:       read_data = stable_s;
      ADDR_RISE_EN:  read_data = rise_en_r;
      ADDR_FALL_EN:  read_data = fall_en_r;
      ADDR_STATUS:   read_data = status_r;
      ADDR_IRQ_MASK: read_data = irq_mask_r;
      default:       read_data = {N{1'b0}};
    endcase
  end

  assign irq = |(status_r & irq_mask_r);

  gpio_port_checker #(.N(N)) u_checker (
    .clock     (clock),
    .reset     (reset),
    .status    (status_r),
    .rise_en   (rise_en_r),
    .fall_en   (fall_en_r),
    .irq_mask  (irq_mask_r),
    .irq       (irq)
  );

endmodule

// -----------------------------------------------------------------------------
// gpio_port_checker
//
// Purpose:
//   Property checks on the interrupt path of gpio_port.
//
// Ports:
//   clock, reset   clock and asynchronous active-high reset of the port
//   status         STATUS register
//   rise_en        RISE_EN register
//   fall_en        FALL_EN register
//   irq_mask       IRQ_MASK register
//   irq            interrupt output
// -----------------------------------------------------------------------------
module gpio_port_checker #(
  parameter int N = 9
) (
  input logic         clock,
  input logic         reset,
  input logic [N-1:0] status,
  input logic [N-1:0] rise_en,
  input logic [N-1:0] fall_en,
  input logic [N-1:0] irq_mask,
  input logic         irq
);

  // irq is exactly the masked OR of STATUS.
  a_irq_matches_status: assert property (
    @(posedge clock) disable iff (reset)
      irq == |(status & irq_mask)
  );

  // A STATUS bit may only become set if one of its edge enables was set.
  a_status_needs_enable: assert property (
    @(posedge clock) disable iff (reset)
      ((status & ~$past(status) & ~($past(rise_en) | $past(fall_en))) == {N{1'b0}})
  );

endmodule

// File: tb/tb_gpio_port.sv
`timescale 1ns/1ps
module tb_gpio_port;

  localparam int N = 9;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 7;   // 2^3-1 cycles of debounce with DEBOUNCE_W=3
`else
  localparam int LAT = 0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [2:0]   address;
  logic         write_enable;
  logic [N-1:0] write_data;
  logic [N-1:0] read_data;
  logic         irq;
  wire  [N-1:0] pin;

  // Bench-side pad drivers, per bit.
  logic [N-1:0] tb_en;
  logic [N-1:0] tb_val;

  int compared   = 0;
  int mismatched = 0;

  for (genvar g = 0; g < N; g++) begin : g_tb_pad
    assign pin[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  gpio_port #(.N(N), .DEBOUNCE_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .irq          (irq),
    .pin          (pin)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is captured by the next posedge and the
  // task returns at the following negedge.
  task automatic wr(input logic [2:0] a, input logic [N-1:0] d);
    address      = a;
    write_data   = d;
    write_enable = 1'b1;
    @(negedge clock);
    write_enable = 1'b0;
    write_data   = '0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [N-1:0] exp, input string tag);
    address = a;
    #1;
    chk(tag, read_data, exp);
  endtask

  initial begin
    reset        = 1'b1;
    address      = 3'd0;
    write_enable = 1'b0;
    write_data   = '0;
    tb_en        = 9'h1FF;
    tb_val       = 9'h000;
    repeat (2) @(negedge clock);

    // Reset state: every address reads zero, irq low.
    for (int a = 0; a < 8; a++) rd(3'(a), 9'h000, "reset_regs");
    chk_bit("reset_irq", irq, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Output mode: DIR=1FF, OUT=0A5.
    tb_en = 9'h000;
    wr(3'd0, 9'h1FF);
    wr(3'd1, 9'h0A5);
    chk("pin_out", pin, 9'h0A5);
    rd(3'd0, 9'h1FF, "dir_readback");
    rd(3'd1, 9'h0A5, "out_readback");
    @(negedge clock);
    rd(3'd2, 9'h000, "in_one_cycle_after");
    repeat (1 + LAT) @(negedge clock);
    rd(3'd2, 9'h0A5, "in_out_readback");

    // Input mode, rising edge on pin[0].
    wr(3'd0, 9'h000);
    tb_en  = 9'h1FF;
    tb_val = 9'h000;
    repeat (3 + LAT) @(negedge clock);
    rd(3'd2, 9'h000, "in_low");
    wr(3'd3, 9'h001);
    wr(3'd6, 9'h001);
    rd(3'd5, 9'h000, "status_before_rise");
    tb_val = 9'h001;
    repeat (3 + LAT) @(negedge clock);
    rd(3'd5, 9'h001, "status_rise0");
    chk_bit("irq_rise0", irq, 1'b1);
    rd(3'd2, 9'h001, "in_pin0_high");

    // Plain clear, then clear racing a fresh rise on pin[0].
    wr(3'd5, 9'h001);
    rd(3'd5, 9'h000, "status_w1c");
    chk_bit("irq_after_w1c", irq, 1'b0);
    tb_val = 9'h000;
    repeat (3 + LAT) @(negedge clock);
    rd(3'd5, 9'h000, "status_fall_not_enabled");
    tb_val = 9'h001;
    repeat (2 + LAT) @(negedge clock);
    wr(3'd5, 9'h001);
    rd(3'd5, 9'h001, "clear_race_set_wins");
    chk_bit("irq_clear_race", irq, 1'b1);
    wr(3'd5, 9'h001);
    rd(3'd5, 9'h000, "status_w1c_after_race");
    chk_bit("irq_w1c_after_race", irq, 1'b0);

    // Masking: falling edge on pin[8] with mask off, then mask on.
    wr(3'd4, 9'h100);
    wr(3'd6, 9'h000);
    tb_val = 9'h101;
    repeat (4 + LAT) @(negedge clock);
    rd(3'd5, 9'h000, "status_rise8_not_enabled");
    tb_val = 9'h001;
    repeat (3 + LAT) @(negedge clock);
    rd(3'd5, 9'h100, "status_fall8");
    chk_bit("irq_masked", irq, 1'b0);
    wr(3'd6, 9'h100);
    chk_bit("irq_unmasked", irq, 1'b1);
    rd(3'd6, 9'h100, "irq_mask_readback");

    // Writes to IN and the reserved address have no effect.
    wr(3'd7, 9'h1FF);
    rd(3'd7, 9'h000, "reserved_reads_zero");
    wr(3'd2, 9'h1FE);
    rd(3'd2, 9'h001, "in_write_ignored");
    rd(3'd5, 9'h100, "status_kept");

    // Mixed directions: pins 4..7 driven by the port, the rest by the bench.
    tb_en = 9'h10F;
    wr(3'd1, 9'h0F0);
    wr(3'd0, 9'h0F0);
    chk("pin_mixed", pin, 9'h0F1);
    repeat (2 + LAT) @(negedge clock);
    rd(3'd2, 9'h0F1, "in_mixed_readback");

    // Mid-run reset: state clears without waiting for a clock edge.
    reset = 1'b1;
    #1;
    chk_bit("rst_async_irq", irq, 1'b0);
    rd(3'd5, 9'h000, "rst_async_status");
    rd(3'd0, 9'h000, "rst_async_dir");
    tb_en  = 9'h1FF;
    tb_val = 9'h0A0;
    #1;
    chk("rst_pins_released", pin, 9'h0A0);
    for (int a = 0; a < 8; a++) rd(3'(a), 9'h000, "rst_regs");
    @(negedge clock);
    reset = 1'b0;
    repeat (3 + LAT) @(negedge clock);
    rd(3'd2, 9'h0A0, "in_after_reset");
    rd(3'd5, 9'h000, "status_after_reset");
    chk_bit("irq_after_reset", irq, 1'b0);

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: a 5-cycle glitch on pin[2] is filtered; a 10-cycle level passes.
    wr(3'd3, 9'h004);
    tb_val = 9'h0A4;
    repeat (5) @(negedge clock);
    tb_val = 9'h0A0;
    repeat (12) @(negedge clock);
    rd(3'd2, 9'h0A0, "db_glitch_in");
    rd(3'd5, 9'h000, "db_glitch_status");
    tb_val = 9'h0A4;
    repeat (10) @(negedge clock);
    rd(3'd2, 9'h0A4, "db_held_in");
    rd(3'd5, 9'h004, "db_held_status");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
